fft8_core: RTL and testbench
============================

FFT8_CORE -- requirements
Module: fft8_core

Interface
REQ-001 SHALL have parameter DATA_W, default 16, sample width (signed two's complement, Q1.(DATA_W-1)).
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  transform request, sampled on rising clk.
REQ-005 SHALL have port in_re_flat  input  8*DATA_W  real inputs; x[i] at bits [(i+1)*DATA_W-1 -: DATA_W].
REQ-006 SHALL have port in_im_flat  input  8*DATA_W  imaginary inputs, same packing.
REQ-007 SHALL have port out_re_flat  output  8*DATA_W  real bins; X[k] at bits [(k+1)*DATA_W-1 -: DATA_W].
REQ-008 SHALL have port out_im_flat  output  8*DATA_W  imaginary bins, same packing.
REQ-009 SHALL have port done  output  1  result-valid level.

Function
REQ-010 SHALL compute X[k] = (1/8)*sum x[n]*exp(-j*2*pi*n*k/8), natural-order output, radix-2 DIT, three stages.
REQ-011 SHALL scale by 1/2 per stage: butterfly sums in DATA_W+1 bits, then arithmetic shift right 1; no overflow possible.
REQ-012 SHALL use Q1.15 twiddles W8^1=(23170,-23170), W8^3=(-23170,-23170); W8^0 and W8^2 (-j) SHALL be exact (pass-through / re-im swap with negation, no multiply).
REQ-013 SHALL form twiddle products in 2*DATA_W bits, arithmetic shift right DATA_W-1, truncating.
REQ-014 SHALL use states IDLE, ST1, ST2, ST3; IDLE->ST1 on start=1, capturing inputs into working registers in bit-reversed order; ST1->ST2->ST3 unconditionally; ST3->IDLE.
REQ-015 SHALL, on the ST3 edge, write results to out_*_flat and set done=1; done rises on the 4th rising edge counting the start-sampling edge as the 1st.
REQ-016 SHALL hold out_*_flat and done=1 stable until the next accepted start; done SHALL clear on the edge that accepts start.
REQ-017 SHALL ignore start while in ST1..ST3; inputs need only be stable on the accepting edge.
REQ-018 SHALL accept start on the same edge done is cleared (back-to-back transforms, 4-cycle throughput).

Reset
REQ-019 SHALL, while rst_n=0, force state=IDLE, done=0, out_re_flat=0, out_im_flat=0, working registers=0, including mid-transform; partial results discarded.
REQ-020 SHALL resume normal operation on the first rising edge after rst_n deasserts.

Configuration
REQ-021 SHALL support macro FFT8_ROUND_EN: defined -> add 1 LSB before every shift-right-1 and add 2^(DATA_W-2) before every twiddle shift (round-half-up); undefined -> truncation per REQ-011/REQ-013. Latency unchanged.

Structure
REQ-022 SHALL place DATA_W default, twiddle constants and the state encoding in shared package fft8_pkg.
REQ-023 SHALL implement the butterfly (twiddle multiply, add/subtract, scale) as sub-module fft8_bfly, four instances shared across stages.

Verification
REQ-024 SHALL cover cosine: x_re = 32767,23169,0,-23169,-32767,-23169,0,23169, x_im=0 -> X1_re,X7_re within 16383+-3, imaginary and all other bins within +-3.
REQ-025 SHALL cover impulse: x_re[0]=32767, rest 0 -> every X_re=4095, every X_im=0 (truncation build).
REQ-026 SHALL cover DC: all x_re=8000 -> X0_re=8000, all other outputs 0; alternating +16384/-16384 -> X4_re=16384, rest 0.
REQ-027 SHALL cover timing: start pulse at edge N -> done=1 after edge N+3, outputs stable while done=1; start during busy ignored.
REQ-028 SHALL cover reset mid-transform: rst_n low during ST2 -> done=0, outputs 0 immediately; next start produces correct result.
REQ-029 SHALL cover imaginary path: x_im[1]=16384, rest 0 -> X_k = (16384/8)*j*W8^k within +-2 LSB.

Source files
------------

// File: rtl/fft8_pkg.sv
// fft8_pkg: shared width default, Q1.15 twiddle constant, state and twiddle encodings
// for the 8-point radix-2 DIT core fft8_core.
package fft8_pkg;

    localparam int DATA_W_DEF = 16;

    // cos(pi/4) in Q1.15; W8^1 = (TW_C, -TW_C), W8^3 = (-TW_C, -TW_C)
    localparam logic signed [15:0] TW_C = 16'sd23170;

    typedef enum logic [1:0] {IDLE, ST1, ST2, ST3} state_e;

    typedef enum logic [1:0] {TW0, TW1, TW2, TW3} tw_e;

    function automatic logic [2:0] bitrev3(input logic [2:0] i);
        return {i[0], i[1], i[2]};
    endfunction

endpackage

// File: rtl/fft8_bfly.sv
// fft8_bfly: scaled radix-2 butterfly y0 = (a + W*b)/2, y1 = (a - W*b)/2.
// Define FFT8_ROUND_EN for round-half-up instead of truncation on every shift.
module fft8_bfly import fft8_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic signed [DATA_W-1:0] a_re,
    input  logic signed [DATA_W-1:0] a_im,
    input  logic signed [DATA_W-1:0] b_re,
    input  logic signed [DATA_W-1:0] b_im,
    input  tw_e                      tw,
    output logic signed [DATA_W-1:0] y0_re,
    output logic signed [DATA_W-1:0] y0_im,
    output logic signed [DATA_W-1:0] y1_re,
    output logic signed [DATA_W-1:0] y1_im
);

    localparam int PW = 2 * DATA_W;
    localparam int SW = DATA_W + 2;

`ifdef FFT8_ROUND_EN
    localparam logic signed [SW-1:0] RND_S = SW'(1);
    localparam logic signed [PW-1:0] RND_P = PW'(1) <<< (DATA_W - 2);
`else
    localparam logic signed [SW-1:0] RND_S = '0;
    localparam logic signed [PW-1:0] RND_P = '0;
`endif

    logic signed [PW-1:0]   w_re, w_im, p_re, p_im;
    logic signed [DATA_W:0] t_re, t_im;

    // NOTE: every variable written here gets a value on every path, so no latch is inferred.
    always_comb begin
        w_re = PW'(TW_C);
        w_im = -PW'(TW_C);
        if (tw == TW3) w_re = -PW'(TW_C);
        p_re = PW'(b_re) * w_re - PW'(b_im) * w_im + RND_P;
        p_im = PW'(b_re) * w_im + PW'(b_im) * w_re + RND_P;
        // W8^0 and W8^2 are exact; -j*b can reach +2^(DATA_W-1), hence the extra bit
        case (tw)
            TW0: begin
                t_re = (DATA_W+1)'(b_re);
                t_im = (DATA_W+1)'(b_im);
            end
            TW2: begin
                t_re = (DATA_W+1)'(b_im);
                t_im = -(DATA_W+1)'(b_re);
            end
            default: begin
                t_re = (DATA_W+1)'(p_re >>> (DATA_W - 1));
                t_im = (DATA_W+1)'(p_im >>> (DATA_W - 1));
            end
        endcase
    end

    assign y0_re = DATA_W'((SW'(a_re) + SW'(t_re) + RND_S) >>> 1);
    assign y0_im = DATA_W'((SW'(a_im) + SW'(t_im) + RND_S) >>> 1);
    assign y1_re = DATA_W'((SW'(a_re) - SW'(t_re) + RND_S) >>> 1);
    assign y1_im = DATA_W'((SW'(a_im) - SW'(t_im) + RND_S) >>> 1);

endmodule

// File: rtl/fft8_core.sv
// fft8_core: 8-point radix-2 DIT FFT, 1/8 scaled, natural-order output, 4-cycle latency.
// Four shared fft8_bfly instances; FFT8_ROUND_EN selects rounding in the butterflies.
module fft8_core import fft8_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [8*DATA_W-1:0] in_re_flat,
    input  logic [8*DATA_W-1:0] in_im_flat,
    output logic [8*DATA_W-1:0] out_re_flat,
    output logic [8*DATA_W-1:0] out_im_flat,
    output logic                done
);

    state_e state, state_nxt;

    logic signed [DATA_W-1:0] wr [8];
    logic signed [DATA_W-1:0] wi [8];

    logic [2:0]               top_idx [4];
    logic [2:0]               bot_idx [4];
    tw_e                      tw_sel  [4];
    logic signed [DATA_W-1:0] y0r [4], y0i [4], y1r [4], y1i [4];

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ST1;
            ST1:     state_nxt = ST2;
            ST2:     state_nxt = ST3;
            ST3:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Butterfly pairing: span 1, 2, 4 for stages 1, 2, 3; default is the stage-3 map
    always_comb begin
        for (int b = 0; b < 4; b++) begin
            top_idx[b] = 3'(b);
            bot_idx[b] = 3'(b + 4);
            tw_sel[b]  = tw_e'(2'(b));
            case (state)
                ST1: begin
                    top_idx[b] = 3'(2 * b);
                    bot_idx[b] = 3'(2 * b + 1);
                    tw_sel[b]  = TW0;
                end
                ST2: begin
                    top_idx[b] = 3'((b / 2) * 4 + b % 2);
                    bot_idx[b] = 3'((b / 2) * 4 + b % 2 + 2);
                    tw_sel[b]  = (b % 2 == 1) ? TW2 : TW0;
                end
                default: ;
            endcase
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_bfly
        fft8_bfly #(.DATA_W(DATA_W)) u_bfly (
            .a_re  (wr[top_idx[g]]),
            .a_im  (wi[top_idx[g]]),
            .b_re  (wr[bot_idx[g]]),
            .b_im  (wi[bot_idx[g]]),
            .tw    (tw_sel[g]),
            .y0_re (y0r[g]),
            .y0_im (y0i[g]),
            .y1_re (y1r[g]),
            .y1_im (y1i[g])
        );
    end

    // NOTE: the working array is reset explicitly so an aborted transform leaves nothing behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                wr[i] <= '0;
                wi[i] <= '0;
            end
            out_re_flat <= '0;
            out_im_flat <= '0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    done <= 1'b0;
                    for (int i = 0; i < 8; i++) begin
                        wr[i] <= in_re_flat[DATA_W*int'(bitrev3(3'(i))) +: DATA_W];
                        wi[i] <= in_im_flat[DATA_W*int'(bitrev3(3'(i))) +: DATA_W];
                    end
                end
                ST1, ST2: begin
                    for (int b = 0; b < 4; b++) begin
                        wr[top_idx[b]] <= y0r[b];
                        wi[top_idx[b]] <= y0i[b];
                        wr[bot_idx[b]] <= y1r[b];
                        wi[bot_idx[b]] <= y1i[b];
                    end
                end
                ST3: begin
                    for (int b = 0; b < 4; b++) begin
                        out_re_flat[b*DATA_W +: DATA_W]     <= y0r[b];
                        out_im_flat[b*DATA_W +: DATA_W]     <= y0i[b];
                        out_re_flat[(b+4)*DATA_W +: DATA_W] <= y1r[b];
                        out_im_flat[(b+4)*DATA_W +: DATA_W] <= y1i[b];
                    end
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fft8_core.sv
// tb_fft8_core: directed vectors with hand-computed bins for fft8_core (DATA_W=16),
// covering reset, impulse, DC, alternating, cosine, imaginary input, timing and mid-run reset.
module tb_fft8_core;

    localparam int W = 16;

`ifdef FFT8_ROUND_EN
    localparam int IMP_V = 4096;
`else
    localparam int IMP_V = 4095;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [8*W-1:0]  in_re_flat = '0;
    logic [8*W-1:0]  in_im_flat = '0;
    logic [8*W-1:0]  out_re_flat, out_im_flat;
    logic            done;

    int n_pass  = 0;
    int n_total = 0;

    int zeros[8]   = '{0, 0, 0, 0, 0, 0, 0, 0};
    int imp_in[8]  = '{32767, 0, 0, 0, 0, 0, 0, 0};
    int imp_exp[8] = '{IMP_V, IMP_V, IMP_V, IMP_V, IMP_V, IMP_V, IMP_V, IMP_V};
    int dc_in[8]   = '{8000, 8000, 8000, 8000, 8000, 8000, 8000, 8000};
    int dc_exp[8]  = '{8000, 0, 0, 0, 0, 0, 0, 0};
    int alt_in[8]  = '{16384, -16384, 16384, -16384, 16384, -16384, 16384, -16384};
    int alt_exp[8] = '{0, 0, 0, 0, 16384, 0, 0, 0};
    int cos_in[8]  = '{32767, 23169, 0, -23169, -32767, -23169, 0, 23169};
    int cos_exp[8] = '{0, 16383, 0, 0, 0, 0, 0, 16383};
    int im_in[8]   = '{0, 16384, 0, 0, 0, 0, 0, 0};
    int im_exp_re[8] = '{0, 1448, 2048, 1448, 0, -1448, -2048, -1448};
    int im_exp_im[8] = '{2048, 1448, 0, -1449, -2048, -1448, 0, 1448};

    fft8_core #(.DATA_W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .in_re_flat  (in_re_flat),
        .in_im_flat  (in_im_flat),
        .out_re_flat (out_re_flat),
        .out_im_flat (out_im_flat),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp_v, input int tol);
        n_total++;
        assert ((obs >= exp_v - tol) && (obs <= exp_v + tol)) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d (tol %0d)", tag, obs, exp_v, tol);
    endtask

    task automatic check_out(input string tag, input int er[8], input int ei[8], input int tol);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("%s_re%0d", tag, k), int'($signed(out_re_flat[k*W +: W])), er[k], tol);
            check($sformatf("%s_im%0d", tag, k), int'($signed(out_im_flat[k*W +: W])), ei[k], tol);
        end
    endtask

    task automatic load(input int re[8], input int im[8]);
        for (int k = 0; k < 8; k++) begin
            in_re_flat[k*W +: W] = W'(re[k]);
            in_im_flat[k*W +: W] = W'(im[k]);
        end
    endtask

    // Waits (bounded) for done after the accepting edge; done must rise on the 3rd edge after it
    task automatic wait_done(input string tag);
        int cyc = 0;
        while (done !== 1'b1 && cyc < 10) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, "_lat"}, cyc, 3, 0);
    endtask

    task automatic run(input string tag, input int re[8], input int im[8]);
        load(re, im);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, "_clr"}, int'(done), 0, 0);
        wait_done(tag);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_done", int'(done), 0, 0);
        check("rst_out", int'(|{out_re_flat, out_im_flat}), 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run("imp", imp_in, zeros);
        check_out("imp", imp_exp, zeros, 0);

        // Timing: accept at edge N, busy start at N+2 ignored, done after N+3
        load(dc_in, zeros);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("t_n0", int'(done), 0, 0);
        @(posedge clk);
        #1;
        check("t_n1", int'(done), 0, 0);
        load(alt_in, zeros);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("t_n2", int'(done), 0, 0);
        @(posedge clk);
        #1;
        check("t_n3", int'(done), 1, 0);
        check_out("dc", dc_exp, zeros, 0);
        repeat (5) @(posedge clk);
        #1;
        check("hold_done", int'(done), 1, 0);
        check_out("hold", dc_exp, zeros, 0);

        run("alt", alt_in, zeros);
        check_out("alt", alt_exp, zeros, 0);

        run("cos", cos_in, zeros);
        check_out("cos", cos_exp, zeros, 3);

        run("imag", zeros, im_in);
        check_out("imag", im_exp_re, im_exp_im, 2);

        // Reset while the next transform sits in ST2
        load(imp_in, zeros);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_done", int'(done), 0, 0);
        check("mid_rst_out", int'(|{out_re_flat, out_im_flat}), 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run("post", dc_in, zeros);
        check_out("post", dc_exp, zeros, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
